inc_counter_bank: RTL and testbench
===================================

# inc_counter_bank

Parametrised bank of independent up/down counters. Each channel increments, decrements or loads under its own strobes, with sticky per-channel overflow flags and a registered, channel-selectable readout. It is the legal, synthesizable home for the increment/decrement behaviour that must never appear in continuous or procedural-continuous assignments. It sits beside datapath blocks that need event counting, and feeds status registers through `out`, `ovf` and `any_ovf`.

## Interface
- `WIDTH`, 4: bits per counter, must be at least 1.
- `CHANNELS`, 4: number of independent counters, must be at least 1.
- `STEP`, 1: increment/decrement amount, must satisfy 1 ≤ STEP < 2^WIDTH.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `inc`  input  CHANNELS  per-channel increment strobe.
- `dec`  input  CHANNELS  per-channel decrement strobe.
- `load`  input  CHANNELS  per-channel load strobe.
- `load_val`  input  WIDTH  value loaded into every channel whose `load` bit is set.
- `clr_flags`  input  1  clears all sticky overflow flags.
- `sel`  input  max(1,$clog2(CHANNELS))  readout channel select. Out-of-range values read as 0.
- `out`  output  WIDTH  registered count of the selected channel.
- `ovf`  output  CHANNELS  sticky per-channel overflow/underflow flags.
- `any_ovf`  output  1  registered OR of all `ovf` bits.

## Operation
- Per-channel priority on each edge, evaluated independently per channel:
  - `load`: cnt ← `load_val`. No flag change.
  - else `inc` and `dec` both high: hold, no flag change.
  - else `inc`: up-step by STEP.
  - else `dec`: down-step by STEP.
  - else hold.
- Wrap mode (default): arithmetic modulo 2^WIDTH.
  - Up-step with cnt + STEP > 2^WIDTH−1 wraps and sets `ovf[i]`.
  - Down-step with cnt < STEP wraps and sets `ovf[i]`.
- Flags:
  - `clr_flags` clears every flag.
  - A wrap/clamp event in the same cycle as `clr_flags` wins: that flag ends up set.
- Readout: `out` ← post-update count of channel `sel`. Out-of-range `sel` gives 0.
- `any_ovf` ← OR of post-update `ovf`.
- Internal sums use WIDTH+1 bits. There is no truncation before the overflow test.

## Timing
- Reset: all counts 0, `ovf` 0, `any_ovf` 0, `out` 0. Applies immediately on `rst` assertion, not on a clock edge.
- Reset asserted mid-operation discards any pending update. The first update after deassertion occurs on the first rising edge with `rst` low.
- Latency:
  - A strobe sampled at edge N is visible on `out` (if selected), `ovf` and `any_ovf` right after edge N.
  - A change to `sel` alone is reflected after the next edge.
- No handshake. Strobes are single-cycle qualifiers. A held strobe counts once per cycle.

## Configuration
- Macro `INC_COUNTER_BANK_SAT_EN`.
- Defined: saturating mode.
  - An up-step that would exceed 2^WIDTH−1 clamps to 2^WIDTH−1.
  - A down-step that would go below 0 clamps to 0.
  - Either clamp sets `ovf[i]`. A step that lands exactly on a bound does not set it.
- Undefined: wrap mode as described under Operation.
- The macro does not change ports, latency or reset values.

## Test plan
Parameters for all scenarios: WIDTH=4, CHANNELS=4, STEP=1.
- Reset: assert `rst` mid-count with ch0=7 -> `out`=0, `ovf`=0000, `any_ovf`=0 before the next edge. After release with `inc[0]` held for 3 edges and `sel`=0 -> `out`=3.
- Wrap: load ch1=15, then `inc[1]` for one edge, `sel`=1 -> `out`=0, `ovf`=0010, `any_ovf`=1. Then `dec[1]` -> `out`=15, flag stays set.
- Saturate (macro defined): load ch2=14, `inc[2]` for 3 edges -> `out`=15 after the 1st, 2nd and 3rd. `ovf[2]` is set only after the 2nd edge. From 0, `dec[2]` -> `out`=0, `ovf[2]`=1.
- Priority: ch3=5 with `load`, `inc` and `dec` all high, `load_val`=9 -> 9. Then `inc`+`dec` high -> 9. Then `dec` only -> 8.
- Flag race: ch0=15 with `inc[0]` and `clr_flags` in the same cycle, `ovf` previously 0100 -> `ovf`=0001.
- Independence: in one cycle, `inc` on ch0, `dec` on ch1, `load` on ch2 (`load_val`=6) -> sweeping `sel` 0..3 reads 1, 15, 6, 0. `ovf`=0010 in wrap mode.

Source files
------------

// File: rtl/inc_counter_bank.sv
// Bank of independent up/down counters with sticky overflow flags and registered readout.
// Define INC_COUNTER_BANK_SAT_EN for saturating steps; default build wraps modulo 2^WIDTH.
module inc_counter_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int STEP     = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [CHANNELS-1:0]                             inc,
    input  logic [CHANNELS-1:0]                             dec,
    input  logic [CHANNELS-1:0]                             load,
    input  logic [WIDTH-1:0]                                load_val,
    input  logic                                            clr_flags,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
    output logic [WIDTH-1:0]                                out,
    output logic [CHANNELS-1:0]                             ovf,
    output logic                                            any_ovf
);

    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_V  = '1;

    logic [WIDTH-1:0]    cnt      [CHANNELS];
    logic [WIDTH-1:0]    cnt_next [CHANNELS];
    logic [WIDTH:0]      up_sum   [CHANNELS];
    logic [WIDTH:0]      dn_dif   [CHANNELS];
    logic [CHANNELS-1:0] wrap_evt;
    logic [CHANNELS-1:0] ovf_next;
    logic [WIDTH-1:0]    out_next;

    // The extra MSB of up_sum/dn_dif is the carry/borrow that flags the event.
    always_comb begin
        wrap_evt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            up_sum[i]   = {1'b0, cnt[i]} + STEP_X;
            dn_dif[i]   = {1'b0, cnt[i]} - STEP_X;
            cnt_next[i] = cnt[i];
            if (load[i]) begin
                cnt_next[i] = load_val;
            end else if (inc[i] && !dec[i]) begin
                wrap_evt[i] = up_sum[i][WIDTH];
`ifdef INC_COUNTER_BANK_SAT_EN
                cnt_next[i] = up_sum[i][WIDTH] ? MAX_V : up_sum[i][WIDTH-1:0];
`else
                cnt_next[i] = up_sum[i][WIDTH-1:0];
`endif
            end else if (dec[i] && !inc[i]) begin
                wrap_evt[i] = dn_dif[i][WIDTH];
`ifdef INC_COUNTER_BANK_SAT_EN
                cnt_next[i] = dn_dif[i][WIDTH] ? '0 : dn_dif[i][WIDTH-1:0];
`else
                cnt_next[i] = dn_dif[i][WIDTH-1:0];
`endif
            end
        end
    end

    // A same-cycle event beats clr_flags.
    always_comb begin
        ovf_next = (clr_flags ? '0 : ovf) | wrap_evt;
        out_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) begin
                out_next = cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            ovf     <= '0;
            out     <= '0;
            any_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_next[i];
            end
            ovf     <= ovf_next;
            out     <= out_next;
            any_ovf <= |ovf_next;
        end
    end

endmodule

// File: tb/tb_inc_counter_bank.sv
// Self-checking bench for inc_counter_bank: directed scenarios plus random traffic
// against an integer-arithmetic reference model.
module tb_inc_counter_bank;

    localparam int WIDTH = 4;
    localparam int CHANNELS = 4;
    localparam int STEP = 1;
    localparam int MODV = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       inc = '0;
    logic [3:0]       dec = '0;
    logic [3:0]       load = '0;
    logic [3:0]       load_val = '0;
    logic             clr_flags = 1'b0;
    logic [1:0]       sel = '0;
    logic [3:0]       out;
    logic [3:0]       ovf;
    logic             any_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_cnt [CHANNELS];
    logic [3:0] m_ovf;
    int         m_out;
    logic       m_any;

    inc_counter_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .sel(sel),
        .out(out), .ovf(ovf), .any_ovf(any_ovf)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        logic [3:0] ev = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            int v;
            if (load[i]) begin
                m_cnt[i] = int'(load_val);
            end else if (inc[i] && !dec[i]) begin
                v = m_cnt[i] + STEP;
                if (v > MODV - 1) begin
                    ev[i] = 1'b1;
`ifdef INC_COUNTER_BANK_SAT_EN
                    v = MODV - 1;
`else
                    v = v - MODV;
`endif
                end
                m_cnt[i] = v;
            end else if (dec[i] && !inc[i]) begin
                v = m_cnt[i] - STEP;
                if (v < 0) begin
                    ev[i] = 1'b1;
`ifdef INC_COUNTER_BANK_SAT_EN
                    v = 0;
`else
                    v = v + MODV;
`endif
                end
                m_cnt[i] = v;
            end
        end
        if (clr_flags) m_ovf = '0;
        m_ovf = m_ovf | ev;
        m_out = (int'(sel) < CHANNELS) ? m_cnt[sel] : 0;
        m_any = (m_ovf != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        inc = '0; dec = '0; load = '0; clr_flags = 1'b0;
        rst = 1'b1;
        #2;
        for (int i = 0; i < CHANNELS; i++) m_cnt[i] = 0;
        m_ovf = '0; m_out = 0; m_any = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (out !== 4'd0 || ovf !== 4'b0000 || any_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init: out=%0d ovf=%b any=%b, want 0 0000 0", out, ovf, any_ovf);
        end
        do_reset();
        @(negedge clk);
        sel = 2'd0; load = 4'b0001; load_val = 4'd7;
        tick();
        load = '0;
        n_cmp++;
        if (out !== 4'd7) begin
            n_bad++;
            $display("FAIL reset_load7: out=%0d want 7", out);
        end
        inc = 4'b0001;
        tick();
        rst = 1'b1;
        #2;
        n_cmp++;
        if (out !== 4'd0 || ovf !== 4'b0000 || any_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: out=%0d ovf=%b any=%b, want 0 0000 0", out, ovf, any_ovf);
        end
        for (int i = 0; i < CHANNELS; i++) m_cnt[i] = 0;
        m_ovf = '0;
        rst = 1'b0;
        tick(); tick(); tick();
        inc = '0;
        n_cmp++;
        if (out !== 4'd3) begin
            n_bad++;
            $display("FAIL reset_release_inc3: out=%0d want 3", out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        sel = 2'd1; load = 4'b0010; load_val = 4'd15;
        tick();
        load = '0; inc = 4'b0010;
        tick();
        inc = '0;
        n_cmp++;
        if (out !== 4'd0 || ovf !== 4'b0010 || any_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_up: out=%0d ovf=%b any=%b, want 0 0010 1", out, ovf, any_ovf);
        end
        dec = 4'b0010;
        tick();
        dec = '0;
        n_cmp++;
        if (out !== 4'd15 || ovf !== 4'b0010) begin
            n_bad++;
            $display("FAIL wrap_down: out=%0d ovf=%b, want 15 0010", out, ovf);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        sel = 2'd2; load = 4'b0100; load_val = 4'd14;
        tick();
        load = '0; inc = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if (out !== 4'd15 || ovf[2] !== (k >= 2)) begin
                n_bad++;
                $display("FAIL sat_up_edge%0d: out=%0d ovf2=%b, want 15 %0d", k, out, ovf[2], (k >= 2));
            end
        end
        inc = '0; load = 4'b0100; load_val = 4'd0; clr_flags = 1'b1;
        tick();
        load = '0; clr_flags = 1'b0; dec = 4'b0100;
        tick();
        dec = '0;
        n_cmp++;
        if (out !== 4'd0 || ovf !== 4'b0100) begin
            n_bad++;
            $display("FAIL sat_down: out=%0d ovf=%b, want 0 0100", out, ovf);
        end
    endtask

    task automatic test_priority();
        do_reset();
        sel = 2'd3; load = 4'b1000; load_val = 4'd5;
        tick();
        inc = 4'b1000; dec = 4'b1000; load_val = 4'd9;
        tick();
        n_cmp++;
        if (out !== 4'd9) begin
            n_bad++;
            $display("FAIL prio_load: out=%0d want 9", out);
        end
        load = '0;
        tick();
        n_cmp++;
        if (out !== 4'd9) begin
            n_bad++;
            $display("FAIL prio_incdec_hold: out=%0d want 9", out);
        end
        inc = '0;
        tick();
        dec = '0;
        n_cmp++;
        if (out !== 4'd8 || ovf !== 4'b0000) begin
            n_bad++;
            $display("FAIL prio_dec: out=%0d ovf=%b, want 8 0000", out, ovf);
        end
    endtask

    task automatic test_flag_race();
        do_reset();
        load = 4'b0001; load_val = 4'd15; dec = 4'b0100;
        tick();
        load = '0; dec = '0;
        n_cmp++;
        if (ovf !== 4'b0100) begin
            n_bad++;
            $display("FAIL race_setup: ovf=%b want 0100", ovf);
        end
        inc = 4'b0001; clr_flags = 1'b1;
        tick();
        inc = '0; clr_flags = 1'b0;
        n_cmp++;
        if (ovf !== 4'b0001 || any_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL race_clr: ovf=%b any=%b, want 0001 1", ovf, any_ovf);
        end
    endtask

    task automatic test_independence();
        int exp_rd [4];
`ifdef INC_COUNTER_BANK_SAT_EN
        exp_rd = '{1, 0, 6, 0};
`else
        exp_rd = '{1, 15, 6, 0};
`endif
        do_reset();
        inc = 4'b0001; dec = 4'b0010; load = 4'b0100; load_val = 4'd6;
        tick();
        inc = '0; dec = '0; load = '0;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            tick();
            n_cmp++;
            if (int'(out) !== exp_rd[k]) begin
                n_bad++;
                $display("FAIL indep_sel%0d: out=%0d want %0d", k, out, exp_rd[k]);
            end
        end
        n_cmp++;
        if (ovf !== 4'b0010) begin
            n_bad++;
            $display("FAIL indep_ovf: ovf=%b want 0010", ovf);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            inc       = 4'($urandom);
            dec       = 4'($urandom);
            load      = 4'($urandom) & 4'($urandom);
            load_val  = 4'($urandom);
            clr_flags = ($urandom_range(0, 7) == 0);
            sel       = 2'($urandom);
            tick();
            n_cmp++;
            if (int'(out) !== m_out || ovf !== m_ovf || any_ovf !== m_any) begin
                n_bad++;
                $display("FAIL random_%0d: out=%0d ovf=%b any=%b, want %0d %b %b",
                         n, out, ovf, any_ovf, m_out, m_ovf, m_any);
            end
        end
        inc = '0; dec = '0; load = '0; clr_flags = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef INC_COUNTER_BANK_SAT_EN
        test_saturate();
`else
        test_wrap();
`endif
        test_priority();
        test_flag_race();
        test_independence();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
